// File: rtl/alu_scan_pkg.sv
// Shared types and constants for the ALU result capture / display-scan stage.
package alu_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SHOW = 2'd2
  } scan_state_e;

  localparam logic DIG_RESULT = 1'b0;
  localparam logic DIG_OPCODE = 1'b1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_SHL = 2'b11;

  function automatic logic [3:0] digit_value(input logic       idx,
                                             input logic [2:0] res,
                                             input logic       cout,
                                             input logic [1:0] sel);
    return (idx == DIG_OPCODE) ? {2'b00, sel} : {cout, res};
  endfunction

endpackage

// File: rtl/alu_scan_timer.sv
// Free-running slot counter for the two-digit scan: slot start, active digit
// index and the anode-off guard window at the beginning of each slot.
module alu_scan_timer #(
  parameter int unsigned SCAN_DIV_W   = 16,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  output logic slot_start,
  output logic digit_idx,
  output logic guard
);

  logic [SCAN_DIV_W-1:0] slot_cnt;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      slot_cnt  <= '0;
      digit_idx <= 1'b0;
    end else begin
      slot_cnt <= slot_cnt + SCAN_DIV_W'(1);
      if (slot_cnt == '1) digit_idx <= ~digit_idx;
    end
  end

  assign slot_start = (slot_cnt == '0);
  assign guard      = (slot_cnt < SCAN_DIV_W'(GUARD_CYCLES));

endmodule

// File: rtl/alu_result_scan.sv
// Captures one ALU result per handshake, holds it, and scans result/opcode
// digits onto a shared 7-segment decoder. Optional: ALU_SCAN_OVF_BLINK_EN.
module alu_result_scan
  import alu_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV_W   = 16,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES  = 50_000_000,
  parameter int unsigned BLINK_W      = 24
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Valid,
  output logic       o_Ready,
  input  logic [2:0] i_Result,
  input  logic       i_Cout,
  input  logic [1:0] i_Sel,
  output logic [3:0] o_Digit_Num,
  output logic [1:0] o_Digit_En_L,
  output logic       o_Showing
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  scan_state_e       state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [2:0]        res_q;
  logic              cout_q;
  logic [1:0]        sel_q;
  logic              accept;
  logic              slot_start;
  logic              digit_idx;
  logic              guard;
  logic              blink_mask;

  assign accept = i_Valid & o_Ready;

  alu_scan_timer #(
    .SCAN_DIV_W  (SCAN_DIV_W),
    .GUARD_CYCLES(GUARD_CYCLES)
  ) u_timer (
    .i_Clk     (i_Clk),
    .i_Rst_L   (i_Rst_L),
    .slot_start(slot_start),
    .digit_idx (digit_idx),
    .guard     (guard)
  );

  // o_Ready is written alongside every state transition so it always equals
  // (next state != HOLD) without a separate next-state decode.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state    <= IDLE;
      o_Ready  <= 1'b0;
      hold_cnt <= '0;
      res_q    <= '0;
      cout_q   <= 1'b0;
      sel_q    <= '0;
    end else begin
      case (state)
        IDLE, SHOW: begin
          if (accept) begin
            res_q    <= i_Result;
            cout_q   <= i_Cout;
            sel_q    <= i_Sel;
            hold_cnt <= HOLD_LOAD;
            state    <= HOLD;
            o_Ready  <= 1'b0;
          end else begin
            o_Ready  <= 1'b1;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state   <= SHOW;
            o_Ready <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
            o_Ready  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          o_Ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef ALU_SCAN_OVF_BLINK_EN
  logic [BLINK_W-1:0] blink_cnt;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) blink_cnt <= '0;
    else          blink_cnt <= blink_cnt + BLINK_W'(1);
  end

  assign blink_mask = cout_q & blink_cnt[BLINK_W-1];
`else
  assign blink_mask = 1'b0;
`endif

  // Digit value and showing flag only change at slot boundaries, so a capture
  // made mid-slot never tears the digit currently lit.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Digit_Num  <= '0;
      o_Digit_En_L <= '1;
      o_Showing    <= 1'b0;
    end else begin
      if (slot_start) begin
        o_Showing   <= (state != IDLE);
        o_Digit_Num <= (state != IDLE) ? digit_value(digit_idx, res_q, cout_q, sel_q) : '0;
      end
      if (guard || !o_Showing)
        o_Digit_En_L <= '1;
      else if (digit_idx == DIG_OPCODE)
        o_Digit_En_L <= 2'b01;
      else
        o_Digit_En_L <= {1'b1, blink_mask};
    end
  end

endmodule

// File: tb/tb_alu_result_scan.sv
// Randomized scoreboard bench for alu_result_scan with a cycle-level reference model.
module tb_alu_result_scan;
  import alu_scan_pkg::*;

  localparam int SDW  = 4;
  localparam int GRD  = 2;
  localparam int HLD  = 8;
  localparam int SLOT = 1 << SDW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic       ready;
  logic [2:0] res = '0;
  logic       cout = 1'b0;
  logic [1:0] sel = '0;
  logic [3:0] dnum;
  logic [1:0] den_l;
  logic       showing;

  alu_result_scan #(
    .SCAN_DIV_W  (SDW),
    .GUARD_CYCLES(GRD),
    .HOLD_CYCLES (HLD),
    .BLINK_W     (6)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_Valid     (valid),
    .o_Ready     (ready),
    .i_Result    (res),
    .i_Cout      (cout),
    .i_Sel       (sel),
    .o_Digit_Num (dnum),
    .o_Digit_En_L(den_l),
    .o_Showing   (showing)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         acc_cyc;
    logic [2:0] res;
    logic       cout;
    logic [1:0] sel;
  } cap_t;

  cap_t q[$];
  int   cyc = 0;
  int   last_acc = -1;
  int   tests = 0;
  int   fails = 0;

  // Ready is low for HLD cycles after each accepted result, high otherwise once out of reset.
  function automatic bit model_ready(input int c);
    return (c >= 1) && (last_acc < 0 || (c - last_acc) >= HLD);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  // Handshake recorder: every transfer the model predicts is queued for display.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      last_acc = -1;
      q.delete();
    end else begin
      if (valid && model_ready(cyc)) begin
        q.push_back('{cyc + 1, res, cout, sel});
        last_acc = cyc + 1;
      end
      cyc = cyc + 1;
    end
  end

  cap_t shown;
  bit   have = 1'b0;
  int   p, d, exp_num, exp_en;

  always @(negedge clk) begin
    if (!rst_n || cyc == 0) begin
      have  = 1'b0;
      shown = '{0, 3'd0, 1'b0, 2'd0};
      check("rst_ready", int'(ready), 0);
      check("rst_en", int'(den_l), 3);
      check("rst_num", int'(dnum), 0);
      check("rst_showing", int'(showing), 0);
    end else begin
      p = (cyc - 1) % SLOT;
      d = ((cyc - 1) / SLOT) % 2;
      if (p == 0) begin
        while (q.size() > 0 && q[0].acc_cyc < cyc) begin
          shown = q.pop_front();
          have  = 1'b1;
        end
      end
      if (!have)       exp_num = 0;
      else if (d == 1) exp_num = int'(shown.sel);
      else             exp_num = int'(shown.cout) * 8 + int'(shown.res);
      if (p < GRD || !have) exp_en = 3;
      else if (d == 1)      exp_en = 1;
      else                  exp_en = 2;
      check("ready", int'(ready), int'(model_ready(cyc)));
      check("digit_num", int'(dnum), exp_num);
      check("digit_en_l", int'(den_l), exp_en);
      check("showing", int'(showing), int'(have));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      valid = 1'b0;
    end
  endtask

  task automatic send(input logic [2:0] r, input logic c, input logic [1:0] s);
    @(negedge clk); #1;
    valid = 1'b1; res = r; cout = c; sel = s;
    @(negedge clk); #1;
    valid = 1'b0;
  endtask

  initial begin
    bit done;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;
    idle(20);

    send(3'b101, 1'b1, OP_ADD);
    idle(2);
    send(3'b011, 1'b0, OP_SUB);
    idle(60);

    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk); #1;
      if (model_ready(cyc) && ((cyc - 1) % SLOT) == 6) begin
        valid = 1'b1; res = 3'b010; cout = 1'b0; sel = OP_SHL;
        done = 1'b1;
        @(negedge clk); #1;
        valid = 1'b0;
      end
    end
    check("midslot_issued", int'(done), 1);
    idle(60);

    send(3'b110, 1'b1, OP_XOR);
    idle(2);
    @(negedge clk); #2 rst_n = 1'b0;
    idle(3);
    @(negedge clk); #2 rst_n = 1'b1;
    idle(3);
    send(3'b001, 1'b0, OP_SHL);
    idle(50);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk); #1;
      valid = (($urandom % 4) == 0);
      res   = 3'($urandom);
      cout  = 1'($urandom);
      sel   = 2'($urandom);
    end
    idle(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
